mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
// Memory-side responder for the byte-wide unified RAM. Serves word fetch requests from the
// instruction-fetch unit (the "mem_send/mem_addr -> mem_valid/mem_val" handshake) and
// load/store requests from the load-store buffer. Each request becomes a byte-serial RAM
// sequence. Results return as one-cycle valid pulses.
// PARAMETERS
// IO_ADDR_HI  18'h3  addr[17:16]==2'b11 marks I/O space (0x30000+); writes there honour io_buffer_full
// PORTS
// clk            in   1   clock, rising edge
// rst            in   1   synchronous active-high reset
// rdy            in   1   global ready; 0 freezes all state and outputs
// clear          in   1   branch-mispredict flush (jump_rst); aborts IF fetch and in-flight load
// io_buffer_full in   1   UART buffer full; stalls I/O-space write bytes
// if_send        in   1   IF fetch request, level, held until if_valid seen
// if_addr        in   32  fetch address, word aligned
// if_valid       out  1   one-cycle pulse: if_val holds fetched word
// if_val         out  32  fetched instruction, little-endian
// lsb_send       in   1   LSB request, level, held until lsb_valid seen
// lsb_wr         in   1   1=store, 0=load
// lsb_len        in   2   00=byte, 01=half, 10=word (11 illegal, treated as word)
// lsb_addr       in   32  byte address
// lsb_wdata      in   32  store data, low bytes used
// lsb_valid      out  1   one-cycle pulse: load data ready / store complete
// lsb_rdata      out  32  load data, zero-extended (sign extension done in LSB)
// mem_din        in   8   RAM read byte, valid 1 cycle after mem_a
// mem_dout       out  8   RAM write byte
// mem_a          out  32  RAM byte address
// mem_wr         out  1   1=write mem_dout to mem_a this cycle
// BEHAVIOUR
// - Reset: state=IDLE; if_valid, lsb_valid, mem_wr=0; mem_a, mem_dout, if_val, lsb_rdata=0.
// - States: IDLE, READ, WRITE, DONE. cnt (3b) counts bytes, N = 1/2/4 from length.
// - IDLE: lsb_send has priority over if_send. On accept edge: latch addr/len/owner,
//   mem_a<=addr, cnt<=0; store also mem_wr<=1, mem_dout<=wdata[7:0]; -> READ or WRITE.
//   IF requests always N=4, owner=IF. clear=1 in IDLE blocks IF accept that edge.
// - READ: each edge buf[8*cnt+:8]<=mem_din, mem_a<=base+cnt+1, cnt++. Edge capturing byte
//   N-1 drives owner's valid<=1 and data<=assembled value, -> DONE. Latency: valid high
//   after edge N counted from accept edge (word: 4, byte: 1).
// - WRITE: each edge writes next byte (mem_a=base+cnt, mem_dout=wdata byte cnt, mem_wr=1);
//   after byte N-1 written, next edge mem_wr<=0, lsb_valid<=1, -> DONE. Latency N.
//   I/O-space byte with io_buffer_full=1: mem_wr<=0, hold cnt/address, retry next edge.
// - DONE: valid pulses drop to 0, mem_wr=0, mem_a<=0; -> IDLE. Mandatory 1-cycle gap so
//   a requester lowering send on the valid edge is not re-accepted.
// - clear=1 during READ owned by IF or by LSB load: -> IDLE next edge, no valid pulse,
//   mem_a<=0. Stores (WRITE) never aborted: they are committed. clear has no effect in DONE.
// - Address arithmetic is 32-bit modulo; base+cnt wraps at 2^32 without error.
// - rdy=0: no register updates (incl. cnt, mem_wr, valids); resumes exactly where it stopped.
// - Simultaneous if_send and lsb_send: LSB served first; IF accepted on first IDLE after DONE.
// - rst mid-transaction: immediate return to reset values; no valid pulse, mem_wr=0.
// TESTING
// - IF fetch: RAM[0x100..0x103]=13,05,00,00, if_send addr 0x100 -> if_valid 1 cycle, 4 edges
//   after accept, if_val=0x00000513; mem_a sequence 100,101,102,103.
// - LSB byte load 0x203 with RAM=0xF0 -> lsb_valid after 1 edge, lsb_rdata=0x000000F0;
//   half store 0xBEEF to 0x210 -> RAM[210]=EF, RAM[211]=BE, lsb_valid after 2 edges.
// - if_send and lsb_send (word load 0x400) same cycle -> LSB served first, one DONE gap,
//   then IF fetch; no request accepted twice.
// - clear asserted at cnt=2 of IF fetch -> no if_valid, IDLE next edge; if_send still high
//   -> fetch restarts from byte 0 and completes with correct word.
// - Byte store 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for those
//   3 cycles, then one write, lsb_valid next edge.
// - rdy low 2 cycles mid word load, and rst mid store -> frozen then identical result;
//   reset yields all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Request/response and byte-RAM bus of the unified memory controller.
// The slave side is the controller; the master side is the requesters plus the RAM.
interface mem_ctrl_if;
  logic        if_send;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_val;

  logic        lsb_send;
  logic        lsb_wr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_valid;
  logic [31:0] lsb_rdata;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  if_send, if_addr, lsb_send, lsb_wr, lsb_len, lsb_addr, lsb_wdata, mem_din,
    output if_valid, if_val, lsb_valid, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_send, if_addr, lsb_send, lsb_wr, lsb_len, lsb_addr, lsb_wdata, mem_din,
    input  if_valid, if_val, lsb_valid, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns IF word fetches and LSB loads/stores into RAM
// byte sequences and returns one-cycle valid pulses to the requester.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'h3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  input  logic      clear,
  input  logic      io_buffer_full,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic        own_lsb_q, own_lsb_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_val_q, if_val_d;
  logic        lsb_valid_q, lsb_valid_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic [7:0]  wbyte [4];
  logic [31:0] assembled;
  logic [31:0] next_a;

  for (genvar gi = 0; gi < 4; gi++) begin : g_wbyte
    assign wbyte[gi] = wdata_q[8*gi +: 8];
  end

  function automatic logic io_stall(input logic [31:0] a, input logic full);
    return (a[17:16] == IO_ADDR_HI) && full;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] len);
    case (len)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // buf is cleared on accept, so OR-ing in the new byte also zero-extends short loads
  assign assembled = buf_q | ({24'd0, bus.mem_din} << {cnt_q, 3'b000});
  assign next_a    = base_q + {29'd0, cnt_q} + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      own_lsb_q   <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_val_q    <= '0;
      lsb_valid_q <= 1'b0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      own_lsb_q   <= own_lsb_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_valid_q  <= if_valid_d;
      if_val_q    <= if_val_d;
      lsb_valid_q <= lsb_valid_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    own_lsb_d   = own_lsb_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_valid_d  = 1'b0;
    if_val_d    = if_val_q;
    lsb_valid_d = 1'b0;
    lsb_rdata_d = lsb_rdata_q;

    case (state_q)
      IDLE: begin
        mem_wr_d = 1'b0;
        if (bus.lsb_send) begin
          own_lsb_d = 1'b1;
          base_d    = bus.lsb_addr;
          last_d    = last_idx(bus.lsb_len);
          wdata_d   = bus.lsb_wdata;
          buf_d     = '0;
          mem_a_d   = bus.lsb_addr;
          cnt_d     = '0;
          if (bus.lsb_wr) begin
            mem_dout_d = bus.lsb_wdata[7:0];
            mem_wr_d   = !io_stall(bus.lsb_addr, io_buffer_full);
            state_d    = WRITE;
          end else begin
            state_d = READ;
          end
        end else if (bus.if_send && !clear) begin
          own_lsb_d = 1'b0;
          base_d    = bus.if_addr;
          last_d    = 2'd3;
          buf_d     = '0;
          mem_a_d   = bus.if_addr;
          cnt_d     = '0;
          state_d   = READ;
        end
      end

      READ: begin
        if (clear) begin
          mem_a_d = '0;
          state_d = IDLE;
        end else begin
          buf_d   = assembled;
          mem_a_d = next_a;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q[1:0] == last_q) begin
            state_d = DONE;
            if (own_lsb_q) begin
              lsb_valid_d = 1'b1;
              lsb_rdata_d = assembled;
            end else begin
              if_valid_d = 1'b1;
              if_val_d   = assembled;
            end
          end
        end
      end

      WRITE: begin
        // mem_wr_q low means the current byte was held back by a full I/O buffer
        if (!mem_wr_q) begin
          mem_wr_d = !io_stall(mem_a_q, io_buffer_full);
        end else if (cnt_q[1:0] == last_q) begin
          mem_wr_d    = 1'b0;
          lsb_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          mem_a_d    = next_a;
          mem_dout_d = wbyte[cnt_q[1:0] + 2'd1];
          mem_wr_d   = !io_stall(next_a, io_buffer_full);
        end
      end

      default: begin
        mem_wr_d = 1'b0;
        mem_a_d  = '0;
        state_d  = IDLE;
      end
    endcase
  end

  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_val    = if_val_q;
  assign bus.lsb_valid = lsb_valid_q;
  assign bus.lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM, directed requests, and a byte-level memory model
// that predicts every valid pulse's payload.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, rdy, clear, io_buffer_full;

  mem_ctrl_if bus ();

  mem_ctrl #(.IO_ADDR_HI(2'h3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .io_buffer_full(io_buffer_full), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_store;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_if[$];
  exp_t        exp_lsb[$];
  logic [31:0] ma_log[$];
  logic [7:0]  ram     [0:262143];
  logic [7:0]  ref_ram [0:262143];
  logic        poke_en;
  logic [17:0] poke_a;
  logic [7:0]  poke_d;
  int cyc = 0;
  int wr_count = 0;
  int errors = 0;
  int checks = 0;
  int if_vcyc = 0;
  int lsb_vcyc = 0;

  // RAM device: read data follows mem_a within the cycle, writes land on the edge
  assign bus.mem_din = ram[bus.mem_a[17:0]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (poke_en) ram[poke_a] <= poke_d;
    else if (bus.mem_wr && rdy) begin
      ram[bus.mem_a[17:0]] <= bus.mem_dout;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none required", name);
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] len);
    logic [31:0] v, a;
    v = '0;
    for (int i = 0; i < nbytes(len); i++) begin
      a = addr + 32'(i);
      v[8*i +: 8] = ref_ram[a[17:0]];
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] wdata);
    logic [31:0] a;
    for (int i = 0; i < nbytes(len); i++) begin
      a = addr + 32'(i);
      ref_ram[a[17:0]] = wdata[8*i +: 8];
    end
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
    ref_ram[a] = d;
  endtask

  task automatic push_lsb(input logic wr, input logic [1:0] len, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.is_store = wr; e.addr = addr; e.len = len;
    e.data = wr ? 32'd0 : model_load(addr, len);
    if (wr) model_store(addr, len, wdata);
    exp_lsb.push_back(e);
  endtask

  task automatic req_if(input logic [31:0] addr, output int lat);
    exp_t e;
    e.is_store = 1'b0; e.addr = addr; e.len = 2'b10; e.data = model_load(addr, 2'b10);
    exp_if.push_back(e);
    ma_log.delete();
    bus.if_addr = addr; bus.if_send = 1'b1; lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      ma_log.push_back(bus.mem_a);
      if (bus.if_valid) begin lat = k - 1; if_vcyc = cyc; break; end
    end
    bus.if_send = 1'b0;
  endtask

  task automatic req_lsb(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
    push_lsb(wr, len, addr, wdata);
    bus.lsb_wr = wr; bus.lsb_len = len; bus.lsb_addr = addr; bus.lsb_wdata = wdata;
    bus.lsb_send = 1'b1; lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.lsb_valid) begin lat = k - 1; lsb_vcyc = cyc; break; end
    end
    bus.lsb_send = 1'b0;
  endtask

  task automatic gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Compare process: every valid pulse must match the oldest outstanding expectation
  initial begin
    logic prev_if, prev_lsb;
    exp_t e;
    logic [31:0] a;
    prev_if = 1'b0; prev_lsb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_if = 1'b0; prev_lsb = 1'b0;
      end else if (rdy) begin
        if (bus.if_valid) begin
          if (prev_if) flag("if_valid_width");
          if (exp_if.size() == 0) flag("if_valid_unexpected");
          else begin
            e = exp_if.pop_front();
            chk("if_val_model", bus.if_val, e.data);
          end
        end
        if (bus.lsb_valid) begin
          if (prev_lsb) flag("lsb_valid_width");
          if (exp_lsb.size() == 0) flag("lsb_valid_unexpected");
          else begin
            e = exp_lsb.pop_front();
            if (e.is_store) begin
              for (int i = 0; i < nbytes(e.len); i++) begin
                a = e.addr + 32'(i);
                chk("store_byte_model", {24'd0, ram[a[17:0]]}, {24'd0, ref_ram[a[17:0]]});
              end
            end else begin
              chk("lsb_rdata_model", bus.lsb_rdata, e.data);
            end
          end
        end
        prev_if = bus.if_valid; prev_lsb = bus.lsb_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_l, lat_i, w0;
    logic [31:0] a_hold;
    logic [3:0] mw;
    mw = '0;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0; poke_en = 1'b0;
    poke_a = '0; poke_d = '0;
    bus.if_send = 1'b0; bus.if_addr = '0; bus.lsb_send = 1'b0; bus.lsb_wr = 1'b0;
    bus.lsb_len = '0; bus.lsb_addr = '0; bus.lsb_wdata = '0;

    poke(18'h100, 8'h13); poke(18'h101, 8'h05); poke(18'h102, 8'h00); poke(18'h103, 8'h00);
    poke(18'h104, 8'h93); poke(18'h105, 8'h00); poke(18'h106, 8'h10); poke(18'h107, 8'h00);
    poke(18'h203, 8'hF0);
    poke(18'h400, 8'h11); poke(18'h401, 8'h22); poke(18'h402, 8'h33); poke(18'h403, 8'h44);
    poke(18'h600, 8'hDE); poke(18'h601, 8'hAD); poke(18'h602, 8'hBE); poke(18'h603, 8'hEF);
    poke(18'h3FFFF, 8'h5A); poke(18'h00000, 8'hA5);

    chk("reset_if_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("reset_lsb_valid", {31'd0, bus.lsb_valid}, 32'd0);
    chk("reset_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("reset_mem_a", bus.mem_a, 32'd0);
    chk("reset_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    chk("reset_if_val", bus.if_val, 32'd0);
    chk("reset_lsb_rdata", bus.lsb_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // IF word fetch
    chk("model_pin_fetch", model_load(32'h100, 2'b10), 32'h00000513);
    req_if(32'h100, lat);
    chk("fetch_latency", lat, 32'd4);
    chk("fetch_word", bus.if_val, 32'h00000513);
    for (int i = 0; i < 4; i++) chk("fetch_mem_a_seq", (i < ma_log.size()) ? ma_log[i] : 32'hFFFFFFFF, 32'h100 + 32'(i));
    gap();

    // byte load, half store
    req_lsb(1'b0, 2'b00, 32'h203, 32'h0, lat);
    chk("byte_load_latency", lat, 32'd1);
    chk("byte_load_data", bus.lsb_rdata, 32'h000000F0);
    gap();
    req_lsb(1'b1, 2'b01, 32'h210, 32'h1234BEEF, lat);
    chk("half_store_latency", lat, 32'd2);
    chk("half_store_ram210", {24'd0, ram[18'h210]}, 32'h000000EF);
    chk("half_store_ram211", {24'd0, ram[18'h211]}, 32'h000000BE);
    gap();

    // half load straddling the 2^32 wrap, and len=11 treated as word
    chk("model_pin_wrap", model_load(32'hFFFFFFFF, 2'b01), 32'h0000A55A);
    req_lsb(1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, lat);
    chk("wrap_load_data", bus.lsb_rdata, 32'h0000A55A);
    gap();
    req_lsb(1'b0, 2'b11, 32'h400, 32'h0, lat);
    chk("len3_latency", lat, 32'd4);
    chk("len3_data", bus.lsb_rdata, 32'h44332211);
    gap();

    // simultaneous requests: LSB first, DONE gap, then IF
    fork
      req_lsb(1'b0, 2'b10, 32'h400, 32'h0, lat_l);
      req_if(32'h104, lat_i);
    join
    chk("arb_lsb_latency", lat_l, 32'd4);
    chk("arb_if_latency", lat_i, 32'd10);
    chk("arb_valid_spacing", if_vcyc - lsb_vcyc, 32'd6);
    chk("arb_if_word", bus.if_val, 32'h00100093);
    repeat (4) @(posedge clk);
    #1;

    // clear at cnt=2 of an IF fetch; fetch restarts
    exp_if.push_back({1'b0, 32'h100, 2'b10, model_load(32'h100, 2'b10)});
    bus.if_addr = 32'h100; bus.if_send = 1'b1; lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.if_valid) begin lat = k; break; end
      if (k == 3) clear = 1'b1;
      if (k == 4) begin
        chk("clear_mem_a", bus.mem_a, 32'd0);
        clear = 1'b0;
      end
    end
    bus.if_send = 1'b0;
    chk("clear_restart_edges", lat, 32'd9);
    chk("clear_restart_word", bus.if_val, 32'h00000513);
    gap();

    // I/O byte store held off by io_buffer_full for 3 edges
    w0 = wr_count;
    push_lsb(1'b1, 2'b00, 32'h30000, 32'h41);
    bus.lsb_wr = 1'b1; bus.lsb_len = 2'b00; bus.lsb_addr = 32'h30000; bus.lsb_wdata = 32'h41;
    io_buffer_full = 1'b1; bus.lsb_send = 1'b1; lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.lsb_valid) begin lat = k - 1; break; end
      if (k <= 4) mw[k-1] = bus.mem_wr;
      if (k == 3) io_buffer_full = 1'b0;
    end
    bus.lsb_send = 1'b0;
    chk("io_mem_wr_pattern", {28'd0, mw}, 32'h8);
    chk("io_store_latency", lat, 32'd4);
    gap();
    chk("io_write_count", wr_count - w0, 32'd1);
    chk("io_ram_byte", {24'd0, ram[18'h30000]}, 32'h41);

    // rdy low for 2 edges in the middle of a word load
    push_lsb(1'b0, 2'b10, 32'h600, 32'h0);
    bus.lsb_wr = 1'b0; bus.lsb_len = 2'b10; bus.lsb_addr = 32'h600;
    bus.lsb_send = 1'b1; lat = -1; a_hold = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.lsb_valid) begin lat = k - 1; break; end
      if (k == 2) begin rdy = 1'b0; a_hold = bus.mem_a; end
      if (k == 3) chk("rdy_freeze_mem_a", bus.mem_a, a_hold);
      if (k == 4) rdy = 1'b1;
    end
    bus.lsb_send = 1'b0;
    chk("rdy_load_latency", lat, 32'd6);
    chk("rdy_load_data", bus.lsb_rdata, 32'hEFBEADDE);
    gap();

    // reset in the middle of a word store, then the store is repeated
    bus.lsb_wr = 1'b1; bus.lsb_len = 2'b10; bus.lsb_addr = 32'h500; bus.lsb_wdata = 32'hA1B2C3D4;
    bus.lsb_send = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("midrst_mem_a", bus.mem_a, 32'd0);
    chk("midrst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
    chk("midrst_lsb_valid", {31'd0, bus.lsb_valid}, 32'd0);
    chk("midrst_lsb_rdata", bus.lsb_rdata, 32'd0);
    chk("midrst_if_val", bus.if_val, 32'd0);
    bus.lsb_send = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    req_lsb(1'b1, 2'b10, 32'h500, 32'hA1B2C3D4, lat);
    chk("restore_latency", lat, 32'd4);
    chk("restore_ram503", {24'd0, ram[18'h503]}, 32'hA1);
    repeat (4) @(posedge clk);
    #1;

    chk("if_expect_drained", exp_if.size(), 32'd0);
    chk("lsb_expect_drained", exp_lsb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
